// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg
//   Shared definitions for the boot loader slice: default widths, the
//   sequencer state encoding, the full-word byte enable and a helper that
//   picks the first phase of a load from the sampled word counts.
package boot_loader_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;

  localparam logic [3:0] BYTE_ENB_FULL = 4'b1111;

  typedef enum logic [2:0] {
    BOOT_IDLE   = 3'd0,
    BOOT_LOAD_D = 3'd1,
    BOOT_LOAD_I = 3'd2,
    BOOT_ARM    = 3'd3,
    BOOT_RUN    = 3'd4,
    BOOT_DONE   = 3'd5
  } boot_state_t;

  // Empty phases are skipped: data first, then instructions, else straight to ARM.
  function automatic boot_state_t first_phase(input logic d_nz, input logic i_nz);
    if (d_nz)      return BOOT_LOAD_D;
    else if (i_nz) return BOOT_LOAD_I;
    else           return BOOT_ARM;
  endfunction

endpackage

// File: rtl/boot_addr_gen.sv
// boot_addr_gen
//   Word-index counter shared by both load phases of boot_loader.
//   Ports:
//     clk, rst    clock, asynchronous active-low reset
//     clr         return index to 0 (wins over inc)
//     inc         advance index by one word (wraps modulo 2^(ADDR_WIDTH-2))
//     limit       word count of the current phase
//     byte_addr   index * 4 as a BRAM byte address
//     last        index is the final word of the current phase
module boot_addr_gen
  import boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-3:0] limit,
  output logic [ADDR_WIDTH-1:0] byte_addr,
  output logic                  last
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  logic [IDX_W-1:0] index_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_reg <= '0;
    end else if (clr) begin
      index_reg <= '0;
    end else if (inc) begin
      index_reg <= index_reg + IDX_W'(1);
    end
  end

  assign last      = (index_reg == (limit - IDX_W'(1)));
  assign byte_addr = {index_reg, 2'b00};

endmodule

// File: rtl/boot_loader.sv
// boot_loader
//   Loads data BRAM then instruction BRAM from a valid/ready word stream,
//   holds the core in reset while loading, arms it for one cycle, lets the
//   PC run for run_cycles cycles (0 = until halt) and parks it in DONE.
//   Optional feature macro: BOOT_LOADER_CHECKSUM_EN builds a wrapping sum of
//   every accepted stream word on checksum; without it checksum is 0.
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     start                    begin a load (honoured in IDLE/DONE only)
//     d_words, i_words         word counts, sampled on start
//     run_cycles               run length, sampled on start, 0 = unbounded
//     halt                     RUN -> DONE at the next edge
//     s_valid, s_data, s_ready word stream handshake
//     d_w_* / i_w_*            registered BRAM write ports (byte addresses)
//     d_bram_init_done         data BRAM write port handed to the core
//     i_r_enb, rd_enbl         instruction BRAM / register-file read enables
//     pc_stall, core_rst       PC hold and active-high core reset
//     busy, done, checksum     status
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-3:0] d_words,
  input  logic [ADDR_WIDTH-3:0] i_words,
  input  logic [CNT_WIDTH-1:0]  run_cycles,
  input  logic                  halt,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [3:0]            d_w_byte_enb,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [3:0]            i_w_byte_enb,
  output logic                  d_bram_init_done,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  pc_stall,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  boot_state_t state_reg, state_next;

  logic [IDX_W-1:0]      d_words_reg, i_words_reg;
  logic [CNT_WIDTH-1:0]  run_cycles_reg, run_cnt_reg;
  logic [ADDR_WIDTH-1:0] d_w_addr_reg, i_w_addr_reg;
  logic [DATA_WIDTH-1:0] d_w_dat_reg, i_w_dat_reg;
  logic                  d_w_enb_reg, i_w_enb_reg;

  logic                  start_ok;
  logic                  s_fire;
  logic                  idx_clr;
  logic                  idx_last;
  logic [IDX_W-1:0]      idx_limit;
  logic [ADDR_WIDTH-1:0] idx_byte_addr;
  logic                  run_end;

  assign start_ok  = start && ((state_reg == BOOT_IDLE) || (state_reg == BOOT_DONE));
  assign s_fire    = s_ready && s_valid;
  assign idx_limit = (state_reg == BOOT_LOAD_I) ? i_words_reg : d_words_reg;
  // Index restarts at each load and again between the data and instruction phases.
  assign idx_clr   = start_ok || (s_fire && idx_last);

  // run_cnt_reg counts RUN cycles already completed, so leaving when the
  // incremented value reaches R keeps the PC free for exactly R cycles.
  assign run_end = halt ||
                   ((run_cycles_reg != '0) && ((run_cnt_reg + CNT_WIDTH'(1)) == run_cycles_reg));

  boot_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (idx_clr),
    .inc       (s_fire),
    .limit     (idx_limit),
    .byte_addr (idx_byte_addr),
    .last      (idx_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= BOOT_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    s_ready          = 1'b0;
    core_rst         = 1'b1;
    pc_stall         = 1'b1;
    d_bram_init_done = 1'b0;
    i_r_enb          = 1'b0;
    rd_enbl          = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    case (state_reg)
      BOOT_IDLE: begin
        if (start_ok) state_next = first_phase(d_words != '0, i_words != '0);
      end
      BOOT_LOAD_D: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_fire && idx_last) state_next = first_phase(1'b0, i_words_reg != '0);
      end
      BOOT_LOAD_I: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_fire && idx_last) state_next = BOOT_ARM;
      end
      BOOT_ARM: begin
        busy             = 1'b1;
        d_bram_init_done = 1'b1;
        i_r_enb          = 1'b1;
        rd_enbl          = 1'b1;
        state_next       = BOOT_RUN;
      end
      BOOT_RUN: begin
        busy             = 1'b1;
        core_rst         = 1'b0;
        pc_stall         = 1'b0;
        d_bram_init_done = 1'b1;
        i_r_enb          = 1'b1;
        rd_enbl          = 1'b1;
        if (run_end) state_next = BOOT_DONE;
      end
      BOOT_DONE: begin
        done             = 1'b1;
        core_rst         = 1'b0;
        // Read paths stay enabled so memory can be inspected after the run.
        d_bram_init_done = 1'b1;
        i_r_enb          = 1'b1;
        rd_enbl          = 1'b1;
        if (start_ok) state_next = first_phase(d_words != '0, i_words != '0);
      end
      default: state_next = BOOT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_words_reg    <= '0;
      i_words_reg    <= '0;
      run_cycles_reg <= '0;
      run_cnt_reg    <= '0;
      d_w_enb_reg    <= 1'b0;
      i_w_enb_reg    <= 1'b0;
      d_w_addr_reg   <= '0;
      i_w_addr_reg   <= '0;
      d_w_dat_reg    <= '0;
      i_w_dat_reg    <= '0;
    end else begin
      if (start_ok) begin
        d_words_reg    <= d_words;
        i_words_reg    <= i_words;
        run_cycles_reg <= run_cycles;
      end
      run_cnt_reg <= (state_reg == BOOT_RUN) ? run_cnt_reg + CNT_WIDTH'(1) : '0;
      d_w_enb_reg <= s_fire && (state_reg == BOOT_LOAD_D);
      i_w_enb_reg <= s_fire && (state_reg == BOOT_LOAD_I);
      if (s_fire && (state_reg == BOOT_LOAD_D)) begin
        d_w_addr_reg <= idx_byte_addr;
        d_w_dat_reg  <= s_data;
      end
      if (s_fire && (state_reg == BOOT_LOAD_I)) begin
        i_w_addr_reg <= idx_byte_addr;
        i_w_dat_reg  <= s_data;
      end
    end
  end

  assign d_w_enb      = d_w_enb_reg;
  assign i_w_enb      = i_w_enb_reg;
  assign d_w_addr     = d_w_addr_reg;
  assign i_w_addr     = i_w_addr_reg;
  assign d_w_dat      = d_w_dat_reg;
  assign i_w_dat      = i_w_dat_reg;
  assign d_w_byte_enb = d_w_enb_reg ? BYTE_ENB_FULL : 4'b0000;
  assign i_w_byte_enb = i_w_enb_reg ? BYTE_ENB_FULL : 4'b0000;

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_reg <= '0;
    end else if (start_ok) begin
      checksum_reg <= '0;
    end else if (s_fire) begin
      checksum_reg <= checksum_reg + s_data;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int IW = AW - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] d_words = '0;
  logic [IW-1:0] i_words = '0;
  logic [CW-1:0] run_cycles = '0;
  logic          halt = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;

  logic          s_ready;
  logic [AW-1:0] d_w_addr, i_w_addr;
  logic [DW-1:0] d_w_dat, i_w_dat;
  logic          d_w_enb, i_w_enb;
  logic [3:0]    d_w_byte_enb, i_w_byte_enb;
  logic          d_bram_init_done, i_r_enb, rd_enbl, pc_stall, core_rst, busy, done;
  logic [DW-1:0] checksum;

  boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .d_words(d_words), .i_words(i_words),
    .run_cycles(run_cycles), .halt(halt), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .d_w_byte_enb(d_w_byte_enb), .i_w_addr(i_w_addr), .i_w_dat(i_w_dat),
    .i_w_enb(i_w_enb), .i_w_byte_enb(i_w_byte_enb), .d_bram_init_done(d_bram_init_done),
    .i_r_enb(i_r_enb), .rd_enbl(rd_enbl), .pc_stall(pc_stall), .core_rst(core_rst),
    .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic        is_i;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    int unsigned cyc;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] stream_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every write pulse must match the oldest handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && (d_w_enb || i_w_enb)) begin
      if (sb_q.size() == 0) begin
        check("spurious_write", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("w_both", d_w_enb & i_w_enb, 0);
        check("w_port", i_w_enb, e.is_i);
        check("w_addr", i_w_enb ? i_w_addr : d_w_addr, e.addr);
        check("w_dat", i_w_enb ? i_w_dat : d_w_dat, e.dat);
        check("w_be", i_w_enb ? i_w_byte_enb : d_w_byte_enb, 4'hF);
        check("w_cycle", cyc, e.cyc);
        $display("write %s addr=%h data=%h cyc=%0d", i_w_enb ? "I" : "D",
                 i_w_enb ? i_w_addr : d_w_addr, i_w_enb ? i_w_dat : d_w_dat, cyc);
      end
    end
  end

  task automatic check_reset();
    check("rst_ctrl", {s_ready, d_w_enb, i_w_enb, d_bram_init_done, i_r_enb, rd_enbl,
                       pc_stall, core_rst, busy, done}, 10'b0000001100);
    check("rst_addr", {d_w_addr, i_w_addr}, 0);
    check("rst_dat", {d_w_dat, i_w_dat}, 0);
    check("rst_be", {d_w_byte_enb, i_w_byte_enb}, 0);
    check("rst_checksum", checksum, 0);
  endtask

  task automatic start_load(input int d, input int i, input int r);
    @(posedge clk); #1;
    d_words = IW'(d); i_words = IW'(i); run_cycles = CW'(r); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_ready", s_ready, (d + i) > 0);
    check("start_busy", busy, 1);
    check("start_hold", {core_rst, pc_stall, d_bram_init_done}, 3'b110);
  endtask

  task automatic feed(input int d, input int i, input bit toggle, input bit poke,
                      input int stop_at, output logic [DW-1:0] sum);
    int   idx = 0;
    int   guard = 0;
    exp_t e;
    sum = '0;
    while (idx < d + i) begin
      guard++;
      if (guard > 400) begin
        check("stream_timeout", idx, d + i);
        break;
      end
      s_valid = toggle ? guard[0] : 1'b1;
      s_data  = stream_q[idx];
      if (poke && idx == 1) begin
        start = 1'b1; d_words = '1; i_words = '1; run_cycles = CW'(1);
      end
      @(negedge clk);
      if (s_valid && s_ready) begin
        e.is_i = (idx >= d);
        e.addr = AW'(4 * ((idx >= d) ? idx - d : idx));
        e.dat  = s_data;
        e.cyc  = cyc + 1;
        sb_q.push_back(e);
        sum = sum + s_data;
        idx++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (stop_at > 0 && idx == stop_at) break;
    end
    s_valid = 1'b0;
  endtask

  task automatic finish_load(input int r, input int halt_at, input logic [DW-1:0] sum);
    int rc = 0;
    // One cycle after the final handshake: ARM.
    check("arm_ready_low", s_ready, 0);
    check("arm_ctrl", {core_rst, pc_stall, d_bram_init_done, i_r_enb, rd_enbl, busy}, 6'b111111);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) break;
      if (!pc_stall) rc++;
      halt = (halt_at > 0) && !pc_stall && (rc == halt_at);
    end
    halt = 1'b0;
    check("done_reached", done, 1);
    check("run_len", rc, (halt_at > 0) ? halt_at : r);
    check("done_ctrl", {pc_stall, core_rst, d_bram_init_done, i_r_enb, rd_enbl, busy, s_ready},
          7'b1011100);
`ifdef BOOT_LOADER_CHECKSUM_EN
    check("checksum", checksum, sum);
`else
    check("checksum", checksum, 0);
`endif
    check("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] sum;

    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b1;

    // Two data words, five instructions, back-to-back stream.
    stream_q = {32'h00000001, 32'h00000002, 32'h00100093, 32'h00200113,
                32'h002081b3, 32'h00302623, 32'h0000006f};
    start_load(2, 5, 5);
    feed(2, 5, 1'b0, 1'b0, 0, sum);
    finish_load(5, 0, sum);

    // Same load with s_valid toggling and a stray start mid-load.
    start_load(2, 5, 5);
    feed(2, 5, 1'b1, 1'b1, 0, sum);
    finish_load(5, 0, sum);

    // Data phase skipped.
    stream_q = {32'hcafef00d};
    start_load(0, 1, 3);
    feed(0, 1, 1'b0, 1'b0, 0, sum);
    finish_load(3, 0, sum);

    // Unbounded run stopped by halt in the seventh RUN cycle.
    stream_q = {32'h11111111, 32'h22222222};
    start_load(1, 1, 0);
    feed(1, 1, 1'b0, 1'b0, 0, sum);
    finish_load(0, 7, sum);

    // Checksum wrap.
    stream_q = {32'hffffffff, 32'h00000002};
    start_load(1, 1, 2);
    feed(1, 1, 1'b0, 1'b0, 0, sum);
    finish_load(2, 0, sum);
`ifdef BOOT_LOADER_CHECKSUM_EN
    check("checksum_wrap", checksum, 32'h00000001);
`endif

    // Reset asserted in the middle of LOAD_I.
    stream_q = {32'h00000001, 32'h00000002, 32'h00100093, 32'h00200113,
                32'h002081b3, 32'h00302623, 32'h0000006f};
    start_load(2, 5, 5);
    feed(2, 5, 1'b0, 1'b0, 3, sum);
    #2 rst = 1'b0;
    #1;
    check_reset();
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;

    // Start accepted again after reset, random payload.
    stream_q.delete();
    for (int k = 0; k < 5; k++) stream_q.push_back($urandom);
    start_load(3, 2, 4);
    feed(3, 2, 1'b0, 1'b0, 0, sum);
    finish_load(4, 0, sum);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
